// File: rtl/digital_pll_pkg.sv
// Shared types and default constants for the digital PLL lock monitor.
package digital_pll_pkg;

    // Lock monitor FSM states
    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACQUIRE,
        LOCKED
    } lock_state_t;

    // Default sizing and thresholds
    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned TOL_DEF      = 1;
    localparam int unsigned LOCK_N_DEF   = 4;
    localparam int unsigned UNLOCK_N_DEF = 2;

endpackage

// File: rtl/pll_osc_sync.sv
// Brings the asynchronous reference osc into the PLL clock domain and
// produces a one-cycle pulse on each rising edge of the synchronised level.
module pll_osc_sync (
    input  logic clock,
    input  logic reset,
    input  logic osc,
    output logic osc_edge,
    output logic osc_level
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Two-flop synchroniser followed by the edge-detect history flop
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= osc;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign osc_edge  = sync2 & ~sync3;
    assign osc_level = sync2;

endmodule

// File: rtl/digital_pll_lock_monitor.sv
// Lock monitor for digital_pll: counts PLL clocks per reference period,
// compares against the programmed divider and tracks lock / reference loss.
module digital_pll_lock_monitor
    import digital_pll_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned TOL      = TOL_DEF,
    parameter int unsigned LOCK_N   = LOCK_N_DEF,
    parameter int unsigned UNLOCK_N = UNLOCK_N_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             osc,
    input  logic             enable,
    input  logic [4:0]       div,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             locked,
    output logic             unlock_event,
    output logic             osc_lost
);

    localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_N + 1);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W + 1)'(TOL);

    logic osc_edge;
    logic osc_level_unused;

    lock_state_t      state;
    lock_state_t      state_n;
    logic [4:0]       div_q;
    logic [4:0]       div_q_n;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] count_n;
    logic             count_valid_n;
    logic             locked_n;
    logic             unlock_n;
    logic             osc_lost_n;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_n;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_cnt;
    logic [BAD_W-1:0]  bad_n;
    logic [BAD_W-1:0]  bad_inc;

    logic signed [CNT_W:0] diff;
    logic                  window_good;
    logic                  saturated;

    pll_osc_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .osc       (osc),
        .osc_edge  (osc_edge),
        .osc_level (osc_level_unused)
    );

    // Window judge: signed deviation of the measured period from div
    assign diff        = $signed({1'b0, cnt_r}) - $signed({{(CNT_W - 4){1'b0}}, div_q});
    assign window_good = (diff <= TOL_S) && (diff >= -TOL_S);
    // Once osc_lost is set the counter sits at all-ones; only the first arrival counts
    assign saturated   = (cnt_r == '1) && !osc_lost;
    assign good_inc    = good_cnt + GOOD_W'(1);
    assign bad_inc     = bad_cnt + BAD_W'(1);

    // State, counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            div_q        <= '0;
            cnt_r        <= '0;
            count        <= '0;
            count_valid  <= 1'b0;
            locked       <= 1'b0;
            unlock_event <= 1'b0;
            osc_lost     <= 1'b0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
        end else begin
            state        <= state_n;
            div_q        <= div_q_n;
            cnt_r        <= cnt_n;
            count        <= count_n;
            count_valid  <= count_valid_n;
            locked       <= locked_n;
            unlock_event <= unlock_n;
            osc_lost     <= osc_lost_n;
            good_cnt     <= good_n;
            bad_cnt      <= bad_n;
        end
    end

    // Next-state and output decode, highest-precedence condition first
    always_comb begin
        state_n       = state;
        div_q_n       = div;
        cnt_n         = osc_edge ? CNT_W'(1) : ((cnt_r == '1) ? cnt_r : cnt_r + CNT_W'(1));
        count_n       = count;
        count_valid_n = 1'b0;
        locked_n      = locked;
        unlock_n      = 1'b0;
        osc_lost_n    = osc_lost;
        good_n        = good_cnt;
        bad_n         = bad_cnt;

        if (!enable || (div == '0)) begin
            state_n    = IDLE;
            cnt_n      = '0;
            count_n    = '0;
            locked_n   = 1'b0;
            osc_lost_n = 1'b0;
            good_n     = '0;
            bad_n      = '0;
        end else if (div != div_q) begin
            state_n  = ARM;
            locked_n = 1'b0;
            good_n   = '0;
            bad_n    = '0;
        end else if (state == IDLE) begin
            state_n = ARM;
        end else if (saturated) begin
            state_n    = ARM;
            osc_lost_n = 1'b1;
            locked_n   = 1'b0;
            good_n     = '0;
            bad_n      = '0;
        end else if (osc_edge) begin
            case (state)
                ARM: begin
                    state_n    = ACQUIRE;
                    osc_lost_n = 1'b0;
                    good_n     = '0;
                    bad_n      = '0;
                end
                ACQUIRE: begin
                    count_n       = cnt_r;
                    count_valid_n = 1'b1;
                    if (window_good) begin
                        if (good_inc == GOOD_W'(LOCK_N)) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            good_n   = '0;
                            bad_n    = '0;
                        end else begin
                            good_n = good_inc;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
                LOCKED: begin
                    count_n       = cnt_r;
                    count_valid_n = 1'b1;
                    if (window_good) begin
                        bad_n = '0;
                    end else if (bad_inc == BAD_W'(UNLOCK_N)) begin
                        state_n  = ACQUIRE;
                        locked_n = 1'b0;
                        unlock_n = 1'b1;
                        good_n   = '0;
                        bad_n    = '0;
                    end else begin
                        bad_n = bad_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digital_pll_lock_monitor.sv
// Self-checking bench for digital_pll_lock_monitor: drives osc with known
// periods and predicts each reported window from the lock/unlock rules.
module tb_digital_pll_lock_monitor;

    localparam int TOL      = 1;
    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       osc;
    logic       enable;
    logic [4:0] div;
    logic [7:0] count;
    logic       count_valid;
    logic       locked;
    logic       unlock_event;
    logic       osc_lost;

    typedef struct {
        int cnt;
        bit lk;
        bit ue;
    } win_t;

    win_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise = 0;
    int   cur_div = 8;
    bit   m_armed, m_locked;
    int   m_good, m_bad;
    bit   mon_en = 1'b0;

    digital_pll_lock_monitor #(
        .CNT_W    (8),
        .TOL      (TOL),
        .LOCK_N   (LOCK_N),
        .UNLOCK_N (UNLOCK_N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .osc          (osc),
        .enable       (enable),
        .div          (div),
        .count        (count),
        .count_valid  (count_valid),
        .locked       (locked),
        .unlock_event (unlock_event),
        .osc_lost     (osc_lost)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_count_valid"}, 32'(count_valid), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_unlock_event"}, 32'(unlock_event), 0);
        check({tag, "_osc_lost"}, 32'(osc_lost), 0);
    endtask

    // Next reference edge after a restart only opens a window
    task automatic model_restart();
        check("pending_windows", 32'(exp_q.size()), 0);
        exp_q.delete();
        m_armed  = 1'b0;
        m_locked = 1'b0;
        m_good   = 0;
        m_bad    = 0;
    endtask

    // Predict the outcome of the window closed by a reference edge 'gap' clocks after the previous one
    task automatic model_edge(input int gap);
        win_t w;
        int   dev;
        bit   good;
        if (!m_armed) begin
            m_armed = 1'b1;
            return;
        end
        dev  = gap - cur_div;
        good = (dev <= TOL) && (dev >= -TOL);
        w.ue = 1'b0;
        if (!m_locked) begin
            if (good) begin
                m_good++;
                if (m_good == LOCK_N) begin
                    m_locked = 1'b1;
                    m_bad    = 0;
                end
            end else begin
                m_good = 0;
            end
        end else if (good) begin
            m_bad = 0;
        end else begin
            m_bad++;
            if (m_bad == UNLOCK_N) begin
                m_locked = 1'b0;
                w.ue     = 1'b1;
                m_good   = 0;
                m_bad    = 0;
            end
        end
        w.cnt = (gap > 255) ? 255 : gap;
        w.lk  = m_locked;
        exp_q.push_back(w);
    endtask

    // One osc period of p clocks, rising edge first
    task automatic run_period(input int p);
        @(negedge clock);
        osc = 1'b1;
        model_edge(cyc - last_rise);
        last_rise = cyc;
        repeat (p / 2) @(negedge clock);
        osc = 1'b0;
        repeat (p - p / 2 - 1) @(negedge clock);
    endtask

    task automatic run_seq(input int ps[$]);
        foreach (ps[i]) run_period(ps[i]);
    endtask

    // Let in-flight edges drain, then re-arm the DUT with divider d
    task automatic change_mode(input int d);
        repeat (4) @(negedge clock);
        if (d != cur_div) begin
            div = 5'(d);
        end else begin
            enable = 1'b0;
            @(negedge clock);
            enable = 1'b1;
        end
        cur_div = d;
        model_restart();
    endtask

    // Every reported window must match the next predicted one
    always @(negedge clock) begin
        win_t w;
        if (mon_en) begin
            if (count_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_count_valid", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("count", 32'(count), 32'(w.cnt));
                    check("locked_at_valid", 32'(locked), 32'(w.lk));
                    check("unlock_event_at_valid", 32'(unlock_event), 32'(w.ue));
                end
            end else begin
                check("unlock_without_valid", 32'(unlock_event), 0);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int d, r, p;

        reset  = 1'b1;
        osc    = 1'b0;
        enable = 1'b1;
        div    = 5'd8;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        last_rise = cyc;
        cur_div = 8;
        model_restart();
        mon_en = 1'b1;

        // Lock acquisition at div=8
        run_seq('{8, 8, 8, 8, 8, 8, 8, 8});
        check("acq_locked", 32'(locked), 1);

        // Tolerance edges at div=10
        change_mode(10);
        run_seq('{11, 9, 11, 9, 11, 9});
        check("tol_locked", 32'(locked), 1);
        change_mode(10);
        run_seq('{10, 10, 10, 12, 10, 10, 10});
        check("tol_not_yet_locked", 32'(locked), 0);
        run_seq('{10, 10});
        check("tol_relocked", 32'(locked), 1);

        // Unlock after two bad windows, survive a single bad one
        change_mode(8);
        run_seq('{8, 8, 8, 8, 8, 8, 12, 12, 8});
        check("unlock_locked", 32'(locked), 0);
        run_seq('{8, 8, 8, 8, 12, 8, 8});
        check("single_bad_still_locked", 32'(locked), 1);

        // Reference loss while locked
        waited = 0;
        while (!osc_lost && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        if (osc_lost) begin
            check("osc_lost_delay", 32'(cyc - last_rise), 258);
            check("osc_lost_locked", 32'(locked), 0);
        end else begin
            check("osc_lost_timeout", 0, 1);
        end
        model_restart();
        repeat (20) @(negedge clock);
        check("osc_lost_sticky", 32'(osc_lost), 1);
        run_period(8);
        check("osc_lost_cleared", 32'(osc_lost), 0);
        run_seq('{8, 8, 8, 8, 8});
        check("relock_after_loss", 32'(locked), 1);

        // Divider change while locked
        change_mode(16);
        @(negedge clock);
        check("div_change_unlocked", 32'(locked), 0);
        run_seq('{16, 16, 16, 16, 16, 16});
        check("div16_locked", 32'(locked), 1);

        // enable=0 and div=0 force IDLE
        repeat (4) @(negedge clock);
        check("pending_before_idle", 32'(exp_q.size()), 0);
        enable = 1'b0;
        @(negedge clock);
        check_all_zero("enable_off");
        enable = 1'b1;
        div    = 5'd0;
        @(negedge clock);
        check_all_zero("div_zero");
        div = 5'd8;
        cur_div = 8;
        model_restart();
        run_seq('{8, 8, 8, 8, 8, 8});
        check("after_idle_locked", 32'(locked), 1);

        // Reset mid-window while locked
        run_period(8);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("mid_reset");
        reset = 1'b0;
        model_restart();
        run_seq('{8, 8, 8, 8, 8, 8});
        check("after_reset_locked", 32'(locked), 1);

        // Randomised divider and period mix
        for (int rnd = 0; rnd < 8; rnd++) begin
            d = int'($urandom_range(5, 24));
            change_mode(d);
            for (int k = 0; k < 30; k++) begin
                r = int'($urandom_range(0, 7));
                if (r < 5)       p = d + (r % 3) - 1;
                else if (r == 5) p = d + 2 + int'($urandom_range(0, 1));
                else             p = d - 2 - int'($urandom_range(0, 1));
                run_period(p);
            end
        end

        repeat (6) @(negedge clock);
        check("final_pending", 32'(exp_q.size()), 0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
